// File: rtl/bdu_bit_streamer.sv
// Transmit side of the BDU bit-serial link: latches one query/reference point pair and
// streams it MSB-first, interleaved x,y,z, then reports one result per pair.
module bdu_bit_streamer #(
    parameter int B            = 32,
    parameter int ID_W         = 8,
    parameter int DONE_TIMEOUT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [B-1:0]             i_q_x,
    input  logic [B-1:0]             i_q_y,
    input  logic [B-1:0]             i_q_z,
    input  logic [B-1:0]             i_r_x,
    input  logic [B-1:0]             i_r_y,
    input  logic [B-1:0]             i_r_z,
    input  logic [ID_W-1:0]          i_r_id,
    output logic                     o_valid,
    output logic                     o_q_bit,
    output logic                     o_r_bit,
    output logic [1:0]               o_code,
    output logic [$clog2(B+1)-1:0]   o_b,
    input  logic                     i_bdu_terminate,
    input  logic                     i_bdu_done,
    output logic                     o_res_valid,
    output logic [ID_W-1:0]          o_res_id,
    output logic                     o_res_terminated,
    output logic                     o_res_timeout,
    output logic [$clog2(3*B+1)-1:0] o_res_bits
);
    localparam int BW = $clog2(B + 1);
    localparam int CW = $clog2(3 * B + 1);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [BW-1:0] B_MAX    = BW'(B);
    localparam logic [CW-1:0] BITS_MAX = CW'(3 * B);
    localparam logic [TW-1:0] T_LAST   = TW'(DONE_TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX    = TW'(DONE_TIMEOUT);
    localparam logic [1:0] CODE_X = 2'b01;
    localparam logic [1:0] CODE_Y = 2'b10;
    localparam logic [1:0] CODE_Z = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [B-1:0]    r_qx, r_qy, r_qz, r_rx, r_ry, r_rz;
    logic [ID_W-1:0] r_id;
    logic            r_valid, r_q_bit, r_r_bit;
    logic [1:0]      r_code;
    logic [BW-1:0]   r_b;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_res_valid, r_res_terminated, r_res_timeout;
    logic [ID_W-1:0] r_res_id;
    logic [CW-1:0]   r_res_bits;

    logic w_ready, w_last, w_accept, w_advance, w_to_wait;
    logic w_res, w_res_term, w_res_tmo;

    // The result cycle is already IDLE but must still refuse a new pair.
    assign w_ready = (r_state == S_IDLE) && !r_res_valid;
    assign w_last  = (r_code == CODE_Z) && (r_b == B_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_to_wait   = 1'b0;
        w_res       = 1'b0;
        w_res_term  = 1'b0;
        w_res_tmo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid && w_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (i_bdu_terminate) begin
                    w_res       = 1'b1;
                    w_res_term  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    if (i_bdu_done) begin
                        w_res       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_to_wait   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_bdu_terminate || i_bdu_done || (r_timer == T_LAST)) begin
                    w_res       = 1'b1;
                    w_res_term  = i_bdu_terminate;
                    w_res_tmo   = !i_bdu_terminate && !i_bdu_done;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid          <= 1'b0;
            r_q_bit          <= 1'b0;
            r_r_bit          <= 1'b0;
            r_code           <= 2'b00;
            r_b              <= '0;
            r_cnt            <= '0;
            r_timer          <= '0;
            r_res_valid      <= 1'b0;
            r_res_id         <= '0;
            r_res_terminated <= 1'b0;
            r_res_timeout    <= 1'b0;
            r_res_bits       <= '0;
        end else begin
            r_res_valid <= w_res;
            if (w_res) begin
                r_res_id         <= r_id;
                r_res_terminated <= w_res_term;
                r_res_timeout    <= w_res_tmo;
                r_res_bits       <= r_cnt;
            end
            if (w_accept) begin
                r_valid <= 1'b1;
                r_code  <= CODE_X;
                r_b     <= BW'(1);
                r_cnt   <= CW'(1);
                r_q_bit <= i_q_x[B-1];
                r_r_bit <= i_r_x[B-1];
            end else if (w_advance) begin
                r_valid <= 1'b1;
                r_cnt   <= (r_cnt == BITS_MAX) ? r_cnt : r_cnt + CW'(1);
                case (r_code)
                    CODE_X: begin
                        r_code  <= CODE_Y;
                        r_q_bit <= r_qy[B-1];
                        r_r_bit <= r_ry[B-1];
                    end
                    CODE_Y: begin
                        r_code  <= CODE_Z;
                        r_q_bit <= r_qz[B-1];
                        r_r_bit <= r_rz[B-1];
                    end
                    default: begin
                        r_code  <= CODE_X;
                        r_b     <= r_b + BW'(1);
                        r_q_bit <= r_qx[B-1];
                        r_r_bit <= r_rx[B-1];
                    end
                endcase
            end else begin
                r_valid <= 1'b0;
                r_code  <= 2'b00;
                r_b     <= '0;
                r_q_bit <= 1'b0;
                r_r_bit <= 1'b0;
            end
            if (w_to_wait)                                  r_timer <= '0;
            else if (r_state == S_WAIT && r_timer != T_MAX) r_timer <= r_timer + TW'(1);
        end
    end

    // Each coordinate register keeps its next unsent bit at the MSB; x's first bit leaves at accept.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_qx <= {i_q_x[B-2:0], 1'b0};
            r_rx <= {i_r_x[B-2:0], 1'b0};
            r_qy <= i_q_y;
            r_ry <= i_r_y;
            r_qz <= i_q_z;
            r_rz <= i_r_z;
            r_id <= i_r_id;
        end else if (w_advance) begin
            case (r_code)
                CODE_X: begin
                    r_qy <= {r_qy[B-2:0], 1'b0};
                    r_ry <= {r_ry[B-2:0], 1'b0};
                end
                CODE_Y: begin
                    r_qz <= {r_qz[B-2:0], 1'b0};
                    r_rz <= {r_rz[B-2:0], 1'b0};
                end
                default: begin
                    r_qx <= {r_qx[B-2:0], 1'b0};
                    r_rx <= {r_rx[B-2:0], 1'b0};
                end
            endcase
        end
    end

    assign o_in_ready       = w_ready;
    assign o_valid          = r_valid;
    assign o_q_bit          = r_q_bit;
    assign o_r_bit          = r_r_bit;
    assign o_code           = r_code;
    assign o_b              = r_b;
    assign o_res_valid      = r_res_valid;
    assign o_res_id         = r_res_id;
    assign o_res_terminated = r_res_terminated;
    assign o_res_timeout    = r_res_timeout;
    assign o_res_bits       = r_res_bits;
endmodule
